tile_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA sync generator. Consumes the sync block's pixel coordinates, video_on, p_tick and hsync/vsync.
- Draws the chimp-test board: 640x480 split into an 8-column x 5-row grid of 80x96-pixel tiles. Each tile has a 2-bit state.
- Game logic writes tile states into a shadow register file. A requested swap copies shadow to active only during vertical blank, so a frame never tears.
- rgb and delayed syncs leave the block pipeline-aligned for the DAC/pins.

---
 rtl/tile_renderer.sv | 163 ++++++++++++++++
 tb/tb_tile_renderer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// Chimp-test board pixel generator: an 8x5 grid of tiles drawn through a two-stage
// pixel pipeline, with a shadow tile-state file that is copied to the active file in vertical blank.
module tile_renderer #(
    parameter int          COLS     = 8,
    parameter int          ROWS     = 5,
    parameter int          GAP      = 4,
    parameter logic [11:0] BG_RGB   = 12'h114,
    parameter logic [11:0] HID_RGB  = 12'hFFF,
    parameter logic [11:0] SHOW_RGB = 12'h0F0,
    parameter logic [11:0] ERR_RGB  = 12'hF00,
    parameter logic [11:0] CUR_RGB  = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [1:0]  wr_data,
    output logic        wr_ready,
    input  logic        swap_req,
    output logic        swap_done,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_addr,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int TW     = 640 / COLS;
    localparam int TH     = 480 / ROWS;
    localparam int NTILES = COLS * ROWS;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);

    logic [CW-1:0] col_s, col_r;
    logic [RW-1:0] row_s, row_r;
    logic [9:0]    xo_s, yo_s, xo_r, yo_r;
    logic          von_r, hs_r, vs_r;
    logic [5:0]    idx_s;
    logic          border_s;
    logic [11:0]   rgb_s, rgb_r;
    logic          hsync_r, vsync_r;
    logic [1:0]    shadow_r [NTILES];
    logic [1:0]    active_r [NTILES];
    logic          swap_pending_r, swap_done_r, wr_ready_r;
    logic          swap_point_s, wr_fire_s;

    // Tile coordinate decode by constant range compares; blanking coordinates clamp to the last tile.
    always_comb begin
        col_s = '0;
        row_s = '0;
        for (int c = 1; c < COLS; c++) begin
            col_s = (x >= 10'(c * TW)) ? CW'(c) : col_s;
        end
        for (int r = 1; r < ROWS; r++) begin
            row_s = (y >= 10'(r * TH)) ? RW'(r) : row_s;
        end
        xo_s = x - 10'(int'(col_s) * TW);
        yo_s = y - 10'(int'(row_s) * TH);
    end

    // Colour selection from the stage-1 tile position.
    always_comb begin
        idx_s    = 6'(int'(row_r) * COLS + int'(col_r));
        border_s = (xo_r < 10'(GAP)) || (xo_r >= 10'(TW - GAP)) ||
                   (yo_r < 10'(GAP)) || (yo_r >= 10'(TH - GAP));
        rgb_s    = 12'h000;
        if (!von_r) begin
            rgb_s = 12'h000;
        end else if (border_s) begin
            rgb_s = (cursor_en && (idx_s == cursor_addr)) ? CUR_RGB : BG_RGB;
        end else begin
            case (active_r[idx_s])
                2'd1:    rgb_s = HID_RGB;
                2'd2:    rgb_s = SHOW_RGB;
                2'd3:    rgb_s = ERR_RGB;
                default: rgb_s = BG_RGB;
            endcase
        end
    end

    // Two-stage pixel pipeline; syncs travel with the pixel so all outputs stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r   <= '0;
            row_r   <= '0;
            xo_r    <= 10'd0;
            yo_r    <= 10'd0;
            von_r   <= 1'b0;
            hs_r    <= 1'b0;
            vs_r    <= 1'b0;
            rgb_r   <= 12'h000;
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
        end else if (p_tick) begin
            col_r   <= col_s;
            row_r   <= row_s;
            xo_r    <= xo_s;
            yo_r    <= yo_s;
            von_r   <= video_on;
            hs_r    <= hsync_in;
            vs_r    <= vsync_in;
            rgb_r   <= rgb_s;
            hsync_r <= hs_r;
            vsync_r <= vs_r;
        end
    end

    assign wr_fire_s    = wr_en && wr_ready_r && (wr_addr < 6'(NTILES));
    assign swap_point_s = p_tick && (x == 10'd0) && (y == 10'd480) && swap_pending_r;

    // Shadow file written by game logic; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTILES; i++) begin
                shadow_r[i] <= 2'd0;
            end
        end else if (wr_fire_s) begin
            shadow_r[wr_addr] <= wr_data;
        end
    end

    // Active file changes only at the first pixel of vertical blank, all tiles at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTILES; i++) begin
                active_r[i] <= 2'd0;
            end
        end else if (swap_point_s) begin
            for (int i = 0; i < NTILES; i++) begin
                active_r[i] <= shadow_r[i];
            end
        end
    end

    // Swap handshake: writes are blocked while a copy is pending so the copied frame is consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pending_r <= 1'b0;
            swap_done_r    <= 1'b0;
            wr_ready_r     <= 1'b1;
        end else begin
            swap_done_r <= swap_point_s;
            if (swap_point_s) begin
                swap_pending_r <= 1'b0;
                wr_ready_r     <= 1'b1;
            end else if (swap_req && !swap_pending_r) begin
                swap_pending_r <= 1'b1;
                wr_ready_r     <= 1'b0;
            end
        end
    end

    assign rgb       = rgb_r;
    assign hsync_out = hsync_r;
    assign vsync_out = vsync_r;
    assign swap_done = swap_done_r;
    assign wr_ready  = wr_ready_r;
endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: pixel ticks are driven at chosen coordinates rather
// than full frames, and each rendered pixel is compared against hand-computed colours.
module tb_tile_renderer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = 6'd0;
    logic [1:0]  wr_data = 2'd0;
    logic        wr_ready;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic        cursor_en = 1'b0;
    logic [5:0]  cursor_addr = 6'd0;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;
    logic [11:0] hs_pat, vs_pat;

    tile_renderer dut (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .x(x), .y(y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .swap_req(swap_req), .swap_done(swap_done),
        .cursor_en(cursor_en), .cursor_addr(cursor_addr),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Counts clocks with swap_done high, sampled well after the edge.
    always @(posedge clk) begin
        #2;
        if (swap_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ptick(input int px, input int py, input logic hs, input logic vs);
        @(negedge clk);
        x        = 10'(px);
        y        = 10'(py);
        video_on = (px < 640) && (py < 480);
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_px(input string tag, input int px, input int py, input logic [11:0] exp);
        ptick(px, py, 1'b1, 1'b1);
        ptick(700, 0, 1'b1, 1'b1);
        chk(tag, rgb, exp);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = 2'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_hsync", hsync_out, 1'b0);
        chk("rst_vsync", vsync_out, 1'b0);
        chk("rst_swap_done", swap_done, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        rst_n = 1'b1;

        // Empty board: 2-tick alignment of syncs and colour, visible vs blank.
        hs_pat = 12'b1011_0011_1000;
        vs_pat = 12'b0110_1100_0101;
        for (int i = 0; i < 12; i++) begin
            ptick(((i % 3) == 0) ? 700 : 100 + 20 * i, 200, hs_pat[i], vs_pat[i]);
            if (i > 0) begin
                chk("hsync_dly", hsync_out, hs_pat[i-1]);
                chk("vsync_dly", vsync_out, vs_pat[i-1]);
                chk("rgb_empty", rgb, (((i - 1) % 3) == 0) ? 12'h000 : 12'h114);
            end
        end

        // Write tile 9 hidden, request swap, check it only appears after the swap point.
        wr(9, 1);
        check_px("pre_swap_9", 120, 140, 12'h114);
        pulse_swap();
        chk("ready_low_pending", wr_ready, 1'b0);
        wr(9, 3);
        d0 = done_cnt;
        ptick(0, 479, 1'b1, 1'b1);
        ptick(1, 480, 1'b1, 1'b1);
        chk("ready_low_before_point", wr_ready, 1'b0);
        chk("no_done_before_point", 12'(done_cnt - d0), 12'd0);
        ptick(0, 480, 1'b1, 1'b0);
        chk("swap_done_once", 12'(done_cnt - d0), 12'd1);
        chk("ready_after_swap", wr_ready, 1'b1);
        check_px("tile9_hidden", 120, 140, 12'hFFF);
        check_px("tile9_gap", 82, 96, 12'h114);

        // Shadow write without swap must not reach the screen.
        wr(9, 2);
        check_px("no_early_update", 120, 140, 12'hFFF);
        d0 = done_cnt;
        ptick(0, 480, 1'b1, 1'b0);
        chk("no_swap_without_req", 12'(done_cnt - d0), 12'd0);
        check_px("no_tearing", 120, 140, 12'hFFF);

        // Cursor highlight on borders only.
        cursor_en   = 1'b1;
        cursor_addr = 6'd0;
        check_px("cursor_border", 1, 1, 12'hFF0);
        check_px("cursor_interior", 40, 48, 12'h114);
        check_px("cursor_other_tile", 81, 1, 12'h114);
        cursor_addr = 6'd9;
        check_px("cursor_tile9_border", 80, 100, 12'hFF0);
        check_px("cursor_tile9_interior", 120, 140, 12'hFFF);
        cursor_en = 1'b0;
        check_px("cursor_off", 1, 1, 12'h114);

        // Write and swap request together; duplicate request; out-of-range write.
        wr(0, 1);
        wr(45, 3);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 6'd39;
        wr_data  = 2'd3;
        swap_req = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        swap_req = 1'b0;
        chk("ready_low_combined", wr_ready, 1'b0);
        pulse_swap();
        d0 = done_cnt;
        ptick(0, 480, 1'b1, 1'b0);
        ptick(0, 480, 1'b1, 1'b0);
        chk("single_swap_done", 12'(done_cnt - d0), 12'd1);
        cursor_en   = 1'b1;
        cursor_addr = 6'd0;
        check_px("tile39_error", 600, 400, 12'hF00);
        check_px("tile9_shown", 120, 140, 12'h0F0);
        check_px("tile0_hidden_cursor", 40, 48, 12'hFFF);
        check_px("tile5_untouched", 440, 48, 12'h114);
        cursor_en = 1'b0;

        // Reset mid-frame with a swap pending.
        wr(9, 3);
        pulse_swap();
        check_px("pre_reset_tile9", 120, 140, 12'h0F0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", rgb, 12'h000);
        chk("mid_rst_hsync", hsync_out, 1'b0);
        chk("mid_rst_vsync", vsync_out, 1'b0);
        chk("mid_rst_ready", wr_ready, 1'b1);
        chk("mid_rst_done", swap_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        ptick(0, 480, 1'b1, 1'b0);
        chk("pending_discarded", 12'(done_cnt - d0), 12'd0);
        check_px("post_rst_tile9", 120, 140, 12'h114);
        check_px("post_rst_tile39", 600, 400, 12'h114);
        check_px("post_rst_tile0", 40, 48, 12'h114);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
